// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core sequencer: opcodes, FSM states,
// operand-B select codes and instruction field positions.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUBI = 3'b011;
  localparam logic [2:0] OP_BEQZ = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] OPB_REG  = 2'd0;
  localparam logic [1:0] OPB_IMM  = 2'd1;
  localparam logic [1:0] OPB_ZERO = 2'd2;

  localparam int OP_MSB       = 15;
  localparam int OP_LSB       = 13;
  localparam int RD_MSB       = 12;
  localparam int RD_LSB       = 10;
  localparam int RS1_MSB      = 9;
  localparam int RS1_LSB      = 7;
  localparam int RS2_MSB      = 2;
  localparam int RS2_LSB      = 0;
  localparam int IMM_MSB      = 3;
  localparam int BEQZ_TGT_MSB = 6;

  // The four ALU opcodes are exactly those with the top opcode bit clear.
  function automatic logic writes_reg(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

endpackage

// File: rtl/seq_counters.sv
// Retired-instruction and busy-cycle counters for the core sequencer.
// Both wrap to zero after all-ones.
module seq_counters
  import core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_en,
  input  logic             cycle_en,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
      cycles  <= '0;
    end else begin
      if (retire_en) retired <= retired + CNT_W'(1);
      if (cycle_en)  cycles  <= cycles + CNT_W'(1);
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control unit: fetches one instruction into IR and walks it through
// FETCH/DECODE/EXEC/WB, issuing register-write and PC-advance/branch pulses in WB.
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W      = 10,
  parameter int IMEM_WAIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [15:0]      instr_in,
  input  logic             alu_zero,
  output logic [15:0]      ir,
  output logic [2:0]       alu_opcode,
  output logic [1:0]       opb_sel,
  output logic             rf_we,
  output logic             pc_inc,
  output logic             branch,
  output logic [PC_W-1:0]  branch_address,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       single_step;
  logic       taken;
  logic       fetch_done;
  logic [2:0] op;

  assign op         = ir[OP_MSB:OP_LSB];
  assign fetch_done = (wait_cnt == 4'(IMEM_WAIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the Moore outputs; pulses can only come from WB.
  always_comb begin
    state_nxt      = state;
    busy           = 1'b0;
    halted         = 1'b0;
    rf_we          = 1'b0;
    pc_inc         = 1'b0;
    branch         = 1'b0;
    branch_address = '0;
    case (state)
      S_IDLE:   if (run || step) state_nxt = S_FETCH;
      S_FETCH: begin
        busy = 1'b1;
        if (fetch_done) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        busy      = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        busy = 1'b1;
        if (op == OP_HALT) begin
          state_nxt = S_HALT;
        end else begin
          rf_we = writes_reg(op);
          if (op == OP_JMP) begin
            branch         = 1'b1;
            branch_address = ir[PC_W-1:0];
          end else if (op == OP_BEQZ && taken) begin
            branch         = 1'b1;
            branch_address = PC_W'(ir[BEQZ_TGT_MSB:0]);
          end else begin
            pc_inc = 1'b1;
          end
          state_nxt = (run && !single_step) ? S_FETCH : S_IDLE;
        end
      end
      S_HALT:   halted = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // IR capture, registered decode fields, fetch wait timer and run-mode flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir          <= '0;
      alu_opcode  <= OP_ADD;
      opb_sel     <= OPB_REG;
      wait_cnt    <= '0;
      single_step <= 1'b0;
      taken       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (run)       single_step <= 1'b0;
          else if (step) single_step <= 1'b1;
        end
        S_FETCH: begin
          if (fetch_done) ir <= instr_in;
          else            wait_cnt <= wait_cnt + 4'd1;
        end
        S_DECODE: begin
          alu_opcode <= writes_reg(op) ? op : OP_ADD;
          case (op)
            OP_ADDI, OP_SUBI: opb_sel <= OPB_IMM;
            OP_BEQZ:          opb_sel <= OPB_ZERO;
            default:          opb_sel <= OPB_REG;
          endcase
        end
        S_EXEC: taken <= alu_zero;
        S_WB: begin
          wait_cnt    <= '0;
          single_step <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  seq_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk      (clk),
    .reset    (reset),
    .retire_en(state == S_WB),
    .cycle_en (busy),
    .retired  (retired),
    .cycles   (cycles)
  );

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: instance 0 has no fetch wait, instance 1 has IMEM_WAIT=3
// and 5-bit counters so wrap-around is reached; randomized instructions vs. a spec model.
module tb_core_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic        run_v[2], step_v[2], az_v[2];
  logic [15:0] instr_v[2];
  logic [15:0] ir_v[2];
  logic [2:0]  aop_v[2];
  logic [1:0]  opb_v[2];
  logic        we_v[2], inc_v[2], br_v[2], halt_v[2], busy_v[2];
  logic [9:0]  ba_v[2];
  logic [15:0] ret0, cyc0;
  logic [4:0]  ret1, cyc1;
  logic [15:0] ret_v[2], cyc_v[2];

  int checks = 0;
  int failures = 0;
  int exp_ret[2];
  int exp_cyc[2];

  always #5 clk = ~clk;

  core_sequencer #(.PC_W(10), .IMEM_WAIT(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .run(run_v[0]), .step(step_v[0]),
    .instr_in(instr_v[0]), .alu_zero(az_v[0]), .ir(ir_v[0]),
    .alu_opcode(aop_v[0]), .opb_sel(opb_v[0]), .rf_we(we_v[0]),
    .pc_inc(inc_v[0]), .branch(br_v[0]), .branch_address(ba_v[0]),
    .halted(halt_v[0]), .busy(busy_v[0]), .retired(ret0), .cycles(cyc0)
  );

  core_sequencer #(.PC_W(10), .IMEM_WAIT(3), .CNT_W(5)) dut1 (
    .clk(clk), .reset(reset), .run(run_v[1]), .step(step_v[1]),
    .instr_in(instr_v[1]), .alu_zero(az_v[1]), .ir(ir_v[1]),
    .alu_opcode(aop_v[1]), .opb_sel(opb_v[1]), .rf_we(we_v[1]),
    .pc_inc(inc_v[1]), .branch(br_v[1]), .branch_address(ba_v[1]),
    .halted(halt_v[1]), .busy(busy_v[1]), .retired(ret1), .cycles(cyc1)
  );

  always_comb begin
    ret_v[0] = ret0;
    cyc_v[0] = cyc0;
    ret_v[1] = {11'b0, ret1};
    cyc_v[1] = {11'b0, cyc1};
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int lat_of(input int d);
    return 4 + wait_of(d);
  endfunction

  function automatic int mod_of(input int d);
    return (d == 0) ? 65536 : 32;
  endfunction

  // Instruction-level reference model of what WB should do.
  function automatic logic exp_we(input logic [15:0] i);
    return i[15:13] <= 3'd3;
  endfunction

  function automatic logic exp_br(input logic [15:0] i, input logic az);
    return (i[15:13] == 3'd5) || ((i[15:13] == 3'd4) && az);
  endfunction

  function automatic logic exp_inc(input logic [15:0] i, input logic az);
    return (i[15:13] != 3'd7) && !exp_br(i, az);
  endfunction

  function automatic logic [2:0] exp_aop(input logic [15:0] i);
    return (i[15:13] <= 3'd3) ? i[15:13] : 3'd0;
  endfunction

  function automatic logic [1:0] exp_opb(input logic [15:0] i);
    if (i[15:13] == 3'd2 || i[15:13] == 3'd3) return 2'd1;
    if (i[15:13] == 3'd4) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [9:0] exp_target(input logic [15:0] i);
    return (i[15:13] == 3'd5) ? i[9:0] : {3'b000, i[6:0]};
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  op;
    r  = $urandom();
    op = 3'($urandom_range(0, 6));
    return {op, r[12:0]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      run_v[d] = 1'b0; step_v[d] = 1'b0; az_v[d] = 1'b0;
      instr_v[d] = 16'hC000; exp_ret[d] = 0; exp_cyc[d] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Step one instruction from IDLE and check every cycle until back in IDLE.
  task automatic step_and_check(input int d, input logic [15:0] instr, input logic az);
    int lat;
    logic [4:0] got, want;
    lat = lat_of(d);
    instr_v[d] = instr; az_v[d] = az; step_v[d] = 1'b1;
    @(negedge clk);
    step_v[d] = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      want = {k < lat, (k == lat-1) && exp_we(instr), (k == lat-1) && exp_inc(instr, az),
              (k == lat-1) && exp_br(instr, az), 1'b0};
      got  = {busy_v[d], we_v[d], inc_v[d], br_v[d], halt_v[d]};
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL step_ctrl d%0d instr=%h k=%0d busy/we/inc/br/halt got %b want %b", d, instr, k, got, want);
      end
      if (k == lat-1) begin
        checks++;
        if ({ir_v[d], aop_v[d], opb_v[d]} !== {instr, exp_aop(instr), exp_opb(instr)}) begin
          failures++;
          $display("[TB] FAIL step_decode d%0d ir/aop/opb got %h/%b/%0d want %h/%b/%0d", d,
                   ir_v[d], aop_v[d], opb_v[d], instr, exp_aop(instr), exp_opb(instr));
        end
        if (exp_br(instr, az)) begin
          checks++;
          if (ba_v[d] !== exp_target(instr)) begin
            failures++;
            $display("[TB] FAIL step_target d%0d got %h want %h", d, ba_v[d], exp_target(instr));
          end
        end
      end
      if (k < lat) @(negedge clk);
    end
    exp_ret[d] += 1;
    exp_cyc[d] += lat;
    checks++;
    if (ret_v[d] !== 16'(exp_ret[d] % mod_of(d))) begin
      failures++;
      $display("[TB] FAIL step_retired d%0d got %0d want %0d", d, ret_v[d], exp_ret[d] % mod_of(d));
    end
    checks++;
    if (cyc_v[d] !== 16'(exp_cyc[d] % mod_of(d))) begin
      failures++;
      $display("[TB] FAIL step_cycles d%0d got %0d want %0d", d, cyc_v[d], exp_cyc[d] % mod_of(d));
    end
  endtask

  // Continuous run of n copies of one instruction; run drops during DECODE of the last.
  task automatic run_stream(input int d, input logic [15:0] instr, input logic az,
                            input int n, input logic both);
    int lat, drop_k, total;
    logic wb;
    logic [4:0] got, want;
    lat    = lat_of(d);
    drop_k = (n-1)*lat + wait_of(d) + 1;
    total  = n*lat + 3;
    instr_v[d] = instr; az_v[d] = az; run_v[d] = 1'b1; step_v[d] = both;
    @(negedge clk);
    step_v[d] = 1'b0;
    for (int k = 0; k <= total; k++) begin
      if (k == drop_k) run_v[d] = 1'b0;
      wb   = (k < n*lat) && ((k % lat) == lat-1);
      want = {k < n*lat, wb && exp_we(instr), wb && exp_inc(instr, az), wb && exp_br(instr, az), 1'b0};
      got  = {busy_v[d], we_v[d], inc_v[d], br_v[d], halt_v[d]};
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL stream_ctrl d%0d instr=%h both=%0b k=%0d got %b want %b", d, instr, both, k, got, want);
      end
      if (k < total) @(negedge clk);
    end
    exp_ret[d] += n;
    exp_cyc[d] += n*lat;
    checks++;
    if ({ret_v[d], cyc_v[d]} !== {16'(exp_ret[d] % mod_of(d)), 16'(exp_cyc[d] % mod_of(d))}) begin
      failures++;
      $display("[TB] FAIL stream_counters d%0d got %0d/%0d want %0d/%0d", d, ret_v[d], cyc_v[d],
               exp_ret[d] % mod_of(d), exp_cyc[d] % mod_of(d));
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_v[d], we_v[d], inc_v[d], br_v[d], halt_v[d]} !== 5'b0) begin
        failures++;
        $display("[TB] FAIL reset_ctrl d%0d got %b want 00000", d, {busy_v[d], we_v[d], inc_v[d], br_v[d], halt_v[d]});
      end
      checks++;
      if ({ir_v[d], aop_v[d], opb_v[d], ba_v[d]} !== 31'b0) begin
        failures++;
        $display("[TB] FAIL reset_regs d%0d ir=%h aop=%b opb=%0d ba=%h want all zero", d, ir_v[d], aop_v[d], opb_v[d], ba_v[d]);
      end
      checks++;
      if ({ret_v[d], cyc_v[d]} !== 32'b0) begin
        failures++;
        $display("[TB] FAIL reset_counters d%0d got %0d/%0d want 0/0", d, ret_v[d], cyc_v[d]);
      end
    end
  endtask

  task automatic test_single_step();
    do_reset();
    step_and_check(0, 16'h4483, 1'($urandom_range(0, 1)));
    step_and_check(1, 16'h4483, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_beqz();
    for (int d = 0; d < 2; d++) begin
      step_and_check(d, 16'h8005, 1'b1);
      step_and_check(d, 16'h8005, 1'b0);
    end
  endtask

  task automatic test_jmp_halt(input int d);
    int lat;
    logic [4:0] got, want;
    do_reset();
    lat = lat_of(d);
    instr_v[d] = 16'hA3FF; az_v[d] = 1'b0; run_v[d] = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 2*lat + 10; k++) begin
      if (k >= 2*lat) begin
        run_v[d]  = 1'($urandom_range(0, 1));
        step_v[d] = 1'($urandom_range(0, 1));
      end
      want = {k < 2*lat, 1'b0, 1'b0, k == lat-1, k >= 2*lat};
      got  = {busy_v[d], we_v[d], inc_v[d], br_v[d], halt_v[d]};
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL jmp_halt_ctrl d%0d k=%0d got %b want %b", d, k, got, want);
      end
      if (k == lat-1) begin
        checks++;
        if (ba_v[d] !== 10'h3FF) begin
          failures++;
          $display("[TB] FAIL jmp_target d%0d got %h want 3ff", d, ba_v[d]);
        end
        instr_v[d] = 16'hE000;
      end
      if (k < 2*lat + 10) @(negedge clk);
    end
    checks++;
    if ({ret_v[d], cyc_v[d]} !== {16'd2, 16'(2*lat)}) begin
      failures++;
      $display("[TB] FAIL halt_counters d%0d got %0d/%0d want 2/%0d", d, ret_v[d], cyc_v[d], 2*lat);
    end
    run_v[d] = 1'b0;
    step_v[d] = 1'b0;
  endtask

  task automatic test_fetch_wait();
    do_reset();
    run_stream(1, rand_instr(), 1'($urandom_range(0, 1)), 4, 1'b0);
    run_stream(1, rand_instr(), 1'($urandom_range(0, 1)), 3, 1'b1);
    run_stream(0, rand_instr(), 1'($urandom_range(0, 1)), 3, 1'b1);
    run_stream(0, rand_instr(), 1'($urandom_range(0, 1)), 2, 1'b0);
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 24; i++) begin
      d = int'($urandom_range(0, 1));
      step_and_check(d, rand_instr(), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 1));
      run_stream(d, rand_instr(), 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_exec(input int d);
    logic [31:0] r;
    logic [15:0] instr;
    logic [4:0]  got;
    r = $urandom();
    instr = {3'b000, r[12:1], 1'b1};
    instr_v[d] = instr; step_v[d] = 1'b1;
    @(negedge clk);
    step_v[d] = 1'b0;
    repeat (wait_of(d) + 2) @(negedge clk);
    checks++;
    if (busy_v[d] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_exec_busy d%0d got %b want 1", d, busy_v[d]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ir_v[d], aop_v[d], opb_v[d], ba_v[d], we_v[d], inc_v[d], br_v[d], halt_v[d], busy_v[d],
         ret_v[d], cyc_v[d]} !== 68'b0) begin
      failures++;
      $display("[TB] FAIL mid_exec_reset d%0d ir=%h aop=%b opb=%0d ba=%h pulses=%b ret=%0d cyc=%0d want all zero",
               d, ir_v[d], aop_v[d], opb_v[d], ba_v[d], {we_v[d], inc_v[d], br_v[d], halt_v[d], busy_v[d]},
               ret_v[d], cyc_v[d]);
    end
    for (int j = 0; j < 2; j++) begin
      exp_ret[j] = 0;
      exp_cyc[j] = 0;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      got = {busy_v[d], we_v[d], inc_v[d], br_v[d], halt_v[d]};
      checks++;
      if ({got, ret_v[d]} !== 21'b0) begin
        failures++;
        $display("[TB] FAIL post_reset_idle d%0d k=%0d ctrl=%b retired=%0d want 0/0", d, k, got, ret_v[d]);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      run_v[d] = 1'b0; step_v[d] = 1'b0; az_v[d] = 1'b0; instr_v[d] = 16'hC000;
      exp_ret[d] = 0; exp_cyc[d] = 0;
    end
    reset = 1'b0;
    #12;
    test_reset();
    test_single_step();
    test_beqz();
    test_jmp_halt(0);
    test_jmp_halt(1);
    test_fetch_wait();
    test_random();
    test_reset_mid_exec(1);
    step_and_check(0, rand_instr(), 1'($urandom_range(0, 1)));
    test_reset_mid_exec(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control unit for the 16-bit core.
- Latches each instruction from instruction memory into an instruction register (IR), then steps it through FETCH/DECODE/EXEC/WB.
- Drives register-file write enable, ALU opcode, operand-B select and the program-counter advance/branch controls.
- Adds run/step/halt control and retired-instruction and cycle counters, replacing free-running PC update with sequenced one-instruction-at-a-time execution.

Parameters:
- PC_W, 10, program counter / branch address width.
- IMEM_WAIT, 0, extra FETCH wait cycles before IR capture (0..15).
- CNT_W, 16, width of retired-instruction and cycle counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  level; continuous execution while high.
- step  input  1  pulse; execute exactly one instruction from IDLE.
- instr_in  input  16  instruction memory read data at current pc.
- alu_zero  input  1  ALU zero flag.
- ir  output  16  instruction register.
- alu_opcode  output  3  ALU operation select.
- opb_sel  output  2  operand-B select: 0 = register, 1 = zero-extended ir[3:0], 2 = constant zero.
- rf_we  output  1  register-file write enable, single-cycle pulse.
- pc_inc  output  1  program-counter increment enable, single-cycle pulse.
- branch  output  1  program-counter load pulse.
- branch_address  output  PC_W  PC load value, valid while branch is high.
- halted  output  1  core has executed HALT.
- busy  output  1  high in FETCH, DECODE, EXEC, WB.
- retired  output  CNT_W  count of completed instructions.
- cycles  output  CNT_W  count of clocks spent in non-IDLE, non-HALT states.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State = IDLE.
  - ir, alu_opcode, opb_sel, retired, cycles = 0.
  - rf_we, pc_inc, branch, halted, busy = 0.
  - branch_address = 0.
  - Reset asserted mid-instruction aborts it; no rf_we, pc_inc or branch pulse is issued afterwards.
- Opcode map, ir[15:13]:
  - 000 ADD, 001 SUB, 010 ADDI, 011 SUBI.
  - 100 BEQZ: branch if reg[ir[9:7]] == 0, target = zero-extended ir[6:0].
  - 101 JMP: target = ir[PC_W-1:0].
  - 110 NOP.
  - 111 HALT.
- Operand fields: rd = ir[12:10], rs1 = ir[9:7], rs2 = ir[2:0].
- IDLE:
  - run = 1 goes to FETCH.
  - Otherwise step = 1 goes to FETCH with a single-step flag set.
  - run and step both high: run wins and the single-step flag is cleared.
- FETCH:
  - Lasts 1 + IMEM_WAIT cycles, timed by a wait counter.
  - IR captures instr_in on the last FETCH cycle.
- DECODE (1 cycle):
  - alu_opcode = ir[15:13] for opcodes 000..011, else 000.
  - opb_sel = 1 for ADDI/SUBI, 2 for BEQZ, else 0.
  - Both are held registered through EXEC and WB.
- EXEC (1 cycle): alu_zero is sampled into a taken flag, which is used only for BEQZ.
- WB (1 cycle):
  - rf_we = 1 for opcodes 000..011.
  - branch = 1 with branch_address for JMP or a taken BEQZ; otherwise pc_inc = 1.
  - HALT: no pulses; state goes to HALT.
  - retired increments on every WB, including HALT.
- After WB:
  - Next state is FETCH if run = 1 and the single-step flag is clear.
  - Otherwise next state is IDLE, and the single-step flag clears.
  - run deasserted mid-instruction: the current instruction completes, then the core goes to IDLE.
- HALT: halted = 1, busy = 0; the block leaves HALT only through reset. run and step are ignored.
- Counters:
  - cycles increments on every clock while busy.
  - retired and cycles wrap to 0 at all-ones without saturation.
- Pulses: rf_we, pc_inc and branch are mutually exclusive and are never high outside WB.
- Latency: one instruction takes 4 + IMEM_WAIT clocks from leaving IDLE/WB to the next WB.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants: OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_BEQZ, OP_JMP, OP_NOP, OP_HALT;
  - state encoding: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT;
  - opb_sel codes: OPB_REG, OPB_IMM, OPB_ZERO;
  - instruction field bit positions.
- One natural sub-module, seq_counters: retired and cycles counters with wrap, sharing the async active-low reset.

Test Plan:
- Single step: reset release, run = 0, step pulse with instr_in = 16'h4483 (ADDI rd1, rs1, imm 3), IMEM_WAIT = 0.
  - Required: rf_we high exactly at clock 4 after step, opb_sel = 1, alu_opcode = 010, pc_inc = 1, then IDLE; retired = 1, cycles = 4.
- BEQZ taken: ir = 16'h8005 with alu_zero = 1 in EXEC.
  - Required: WB branch = 1, branch_address = 10'h005, pc_inc = 0, rf_we = 0.
- BEQZ not taken: same instruction with alu_zero = 0.
  - Required: pc_inc = 1, branch = 0.
- JMP then HALT, continuous run = 1:
  - JMP 16'hA3FF gives branch_address = 10'h3FF.
  - Next instruction 16'hE000 sets halted = 1 and busy = 0; later run/step pulses produce no further pulses; retired = 2.
- Fetch wait and mid-run control, IMEM_WAIT = 3:
  - Required: instruction period is 7 clocks.
  - Drop run in DECODE: the instruction completes (one WB pulse), then IDLE.
  - run and step high together in IDLE: continuous execution.
- Reset mid-EXEC: reset low during EXEC of an ADD.
  - Required: all outputs immediately 0, no rf_we; after release the core sits in IDLE with retired = 0.
